// File: rtl/crop_window_ctrl_if.sv
// Pixel-stream and window-configuration signals of the crop window controller.
// The master drives the stream and the config requests; the slave is the controller.
interface crop_window_ctrl_if #(
  parameter int IN_COLS = 40,
  parameter int IN_ROWS = 40
);
  localparam int CW = $clog2(IN_COLS + 1);
  localparam int RW = $clog2(IN_ROWS + 1);
  localparam int KW = $clog2(IN_COLS * IN_ROWS + 1);

  logic          cfg_wr;
  logic [CW-1:0] cfg_x1;
  logic [RW-1:0] cfg_y1;
  logic [CW-1:0] cfg_w;
  logic [RW-1:0] cfg_h;
  logic          cfg_err;
  logic          px_valid;
  logic          px_ready;
  logic          px_sof;
  logic          keep;
  logic [CW-1:0] cur_x;
  logic [RW-1:0] cur_y;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic [KW-1:0] kept_count;

  modport master (
    output cfg_wr, cfg_x1, cfg_y1, cfg_w, cfg_h, px_valid, px_ready, px_sof,
    input  cfg_err, keep, cur_x, cur_y, busy, frame_done, frame_err, kept_count
  );

  modport slave (
    input  cfg_wr, cfg_x1, cfg_y1, cfg_w, cfg_h, px_valid, px_ready, px_sof,
    output cfg_err, keep, cur_x, cur_y, busy, frame_done, frame_err, kept_count
  );
endinterface

// File: rtl/crop_window_ctrl.sv
// Tracks the raster position of a pixel stream and flags beats inside a crop window.
// A shadow window is configurable at any time; it becomes active only on a start-of-frame beat.
module crop_window_ctrl #(
  parameter int IN_COLS = 40,
  parameter int IN_ROWS = 40,
  parameter int DEF_X1  = 10,
  parameter int DEF_Y1  = 10,
  parameter int DEF_W   = 20,
  parameter int DEF_H   = 20
) (
  input logic              clk,
  input logic              reset,
  crop_window_ctrl_if.slave bus
);
  localparam int CW = $clog2(IN_COLS + 1);
  localparam int RW = $clog2(IN_ROWS + 1);
  localparam int KW = $clog2(IN_COLS * IN_ROWS + 1);

  localparam logic [CW:0]   COLS_L   = (CW+1)'(IN_COLS);
  localparam logic [RW:0]   ROWS_L   = (RW+1)'(IN_ROWS);
  localparam logic [KW-1:0] KEPT_MAX = '1;

  if (DEF_W < 1 || DEF_H < 1 || DEF_X1 < 0 || DEF_Y1 < 0 ||
      DEF_X1 + DEF_W > IN_COLS || DEF_Y1 + DEF_H > IN_ROWS) begin : g_bad_default
    $error("crop_window_ctrl: default window does not fit the input frame");
  end

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  typedef struct packed {
    logic [CW-1:0] x1;
    logic [RW-1:0] y1;
    logic [CW-1:0] w;
    logic [RW-1:0] h;
  } win_t;

  localparam win_t DEF_WIN = '{x1: CW'(DEF_X1), y1: RW'(DEF_Y1), w: CW'(DEF_W), h: RW'(DEF_H)};

  state_t        r_state, w_next_state;
  win_t          r_shadow, r_active, w_win, w_cfg;
  logic [CW-1:0] r_x, w_cur_x, w_nx;
  logic [RW-1:0] r_y, w_cur_y, w_ny;
  logic [KW-1:0] r_kept, r_kept_count, w_kept_base, w_kept_next;
  logic          r_cfg_err, r_frame_done, r_frame_err;
  logic          w_beat, w_sof_px, w_sof_beat, w_in_frame;
  logic          w_x_in, w_y_in, w_keep, w_last, w_cfg_ok, w_busy;

  assign w_beat     = bus.px_valid & bus.px_ready;
  assign w_sof_px   = bus.px_valid & bus.px_sof;
  assign w_sof_beat = w_beat & bus.px_sof;
  assign w_in_frame = w_beat & ((r_state == S_ACTIVE) | bus.px_sof);

  // A presented sof pixel is (0,0) of the next frame and is judged against the shadow window.
  assign w_win   = w_sof_px ? r_shadow : r_active;
  assign w_cur_x = w_sof_px ? '0 : r_x;
  assign w_cur_y = w_sof_px ? '0 : r_y;

  assign w_x_in = (w_cur_x >= w_win.x1) &&
                  ((CW+1)'(w_cur_x) < (CW+1)'(w_win.x1) + (CW+1)'(w_win.w));
  assign w_y_in = (w_cur_y >= w_win.y1) &&
                  ((RW+1)'(w_cur_y) < (RW+1)'(w_win.y1) + (RW+1)'(w_win.h));
  assign w_keep = w_in_frame & w_x_in & w_y_in;
  assign w_last = (w_cur_x == CW'(IN_COLS - 1)) && (w_cur_y == RW'(IN_ROWS - 1));

  assign w_kept_base = w_sof_beat ? '0 : r_kept;
  assign w_kept_next = (w_keep && w_kept_base != KEPT_MAX) ? w_kept_base + 1'b1 : w_kept_base;

  assign w_cfg    = '{x1: bus.cfg_x1, y1: bus.cfg_y1, w: bus.cfg_w, h: bus.cfg_h};
  assign w_cfg_ok = (bus.cfg_w != '0) && (bus.cfg_h != '0) &&
                    ((CW+1)'(bus.cfg_x1) + (CW+1)'(bus.cfg_w) <= COLS_L) &&
                    ((RW+1)'(bus.cfg_y1) + (RW+1)'(bus.cfg_h) <= ROWS_L);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_nx = w_cur_x + 1'b1;
    w_ny = w_cur_y;
    if (w_last) begin
      w_nx = '0;
      w_ny = '0;
    end else if (w_cur_x == CW'(IN_COLS - 1)) begin
      w_nx = '0;
      w_ny = w_cur_y + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_in_frame) w_next_state = w_last ? S_IDLE : S_ACTIVE;
  end

  always_comb begin
    w_busy = (r_state == S_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow     <= DEF_WIN;
      r_active     <= DEF_WIN;
      r_x          <= '0;
      r_y          <= '0;
      r_kept       <= '0;
      r_kept_count <= '0;
      r_cfg_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cfg_err    <= bus.cfg_wr & ~w_cfg_ok;
      r_frame_done <= w_in_frame & w_last;
      r_frame_err  <= w_sof_beat & (r_state == S_ACTIVE);
      if (bus.cfg_wr && w_cfg_ok) r_shadow <= w_cfg;
      if (w_in_frame) begin
        if (w_sof_beat) r_active <= r_shadow;
        r_x <= w_nx;
        r_y <= w_ny;
        if (w_last) begin
          r_kept       <= '0;
          r_kept_count <= w_kept_next;
        end else begin
          r_kept <= w_kept_next;
        end
      end
    end
  end

  assign bus.keep       = w_keep;
  assign bus.cur_x      = w_cur_x;
  assign bus.cur_y      = w_cur_y;
  assign bus.busy       = w_busy;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.kept_count = r_kept_count;
endmodule

// File: tb/tb_crop_window_ctrl.sv
// Self-checking bench for crop_window_ctrl on a 40x40 frame with a 20x20 default window.
// A behavioural model feeds a one-deep scoreboard of registered outputs; scenarios add fixed checks.
module tb_crop_window_ctrl;
  localparam int COLS = 40;
  localparam int ROWS = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crop_window_ctrl_if #(.IN_COLS(COLS), .IN_ROWS(ROWS)) bus ();

  crop_window_ctrl #(
    .IN_COLS(COLS), .IN_ROWS(ROWS),
    .DEF_X1(10), .DEF_Y1(10), .DEF_W(20), .DEF_H(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        ferr;
    logic        cerr;
    logic [10:0] kc;
  } exp_t;

  typedef struct {
    int x1;
    int y1;
    int w;
    int h;
  } mwin_t;

  exp_t q_exp[$];
  int   q_cx[$];
  int   q_cy[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_keep = 0;

  bit    m_busy;
  int    m_x, m_y, m_kept, m_kc;
  mwin_t m_sh, m_ac;

  function automatic mwin_t def_win();
    mwin_t d;
    d.x1 = 10; d.y1 = 10; d.w = 20; d.h = 20;
    return d;
  endfunction

  // One clock: check last cycle's registered outputs, drive, check combinational outputs, advance model.
  task automatic cycle(input bit v, input bit r, input bit s, input bit wr,
                       input int x1, input int y1, input int w, input int h, input bit rst);
    exp_t  e, got;
    mwin_t win;
    int    cx, cy;
    bit    sofp, beat, ek;
    @(posedge clk);
    #1;
    got = {bus.busy, bus.frame_done, bus.frame_err, bus.cfg_err, bus.kept_count};
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL regs busy/done/ferr/cerr/kept got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                 got.busy, got.done, got.ferr, got.cerr, got.kc,
                 e.busy, e.done, e.ferr, e.cerr, e.kc);
      end
    end
    if (got.done === 1'b1) n_done++;
    if (got.ferr === 1'b1) n_ferr++;

    reset        = rst;
    bus.px_valid = v;
    bus.px_ready = r;
    bus.px_sof   = s;
    bus.cfg_wr   = wr;
    bus.cfg_x1   = 6'(x1);
    bus.cfg_y1   = 6'(y1);
    bus.cfg_w    = 6'(w);
    bus.cfg_h    = 6'(h);

    sofp = v && s;
    beat = v && r;
    win  = sofp ? m_sh : m_ac;
    cx   = sofp ? 0 : m_x;
    cy   = sofp ? 0 : m_y;
    ek   = beat && (m_busy || sofp) && cx >= win.x1 && cx < win.x1 + win.w &&
           cy >= win.y1 && cy < win.y1 + win.h;

    @(negedge clk);
    if (!rst) begin
      n_cmp++;
      if ({bus.keep, bus.cur_x, bus.cur_y} !== {ek, 6'(cx), 6'(cy)}) begin
        n_err++;
        $display("FAIL comb keep/x/y got %b/%0d/%0d want %b/%0d/%0d",
                 bus.keep, bus.cur_x, bus.cur_y, ek, cx, cy);
      end
      if (beat) begin
        q_cx.push_back(int'(bus.cur_x));
        q_cy.push_back(int'(bus.cur_y));
      end
    end
    if (bus.keep === 1'b1) n_keep++;

    e = '0;
    if (rst) begin
      m_busy = 0; m_x = 0; m_y = 0; m_kept = 0; m_kc = 0;
      m_sh = def_win(); m_ac = def_win();
    end else begin
      if (beat && (m_busy || s)) begin
        if (s) begin
          e.ferr = m_busy;
          m_ac   = m_sh;
          m_kept = 0;
        end
        if (ek && m_kept < 2047) m_kept++;
        if (cx == COLS - 1 && cy == ROWS - 1) begin
          e.done = 1; m_kc = m_kept; m_busy = 0; m_x = 0; m_y = 0; m_kept = 0;
        end else begin
          m_busy = 1;
          if (cx == COLS - 1) begin m_x = 0; m_y = cy + 1; end
          else begin m_x = cx + 1; m_y = cy; end
        end
      end
      if (wr) begin
        if (w >= 1 && h >= 1 && x1 + w <= COLS && y1 + h <= ROWS) begin
          m_sh.x1 = x1; m_sh.y1 = y1; m_sh.w = w; m_sh.h = h;
        end else begin
          e.cerr = 1;
        end
      end
    end
    e.busy = m_busy;
    e.kc   = 11'(m_kc);
    q_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beats(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) cycle(1, 1, first_sof && i == 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    n_cmp++;
    if ({bus.busy, bus.frame_done, bus.frame_err, bus.cfg_err} !== 4'b0000 || bus.kept_count !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state busy/done/ferr/cerr/kept got %b/%b/%b/%b/%0d want 0/0/0/0/0",
               bus.busy, bus.frame_done, bus.frame_err, bus.cfg_err, bus.kept_count);
    end
  endtask

  task automatic test_default_frame();
    n_done = 0; n_keep = 0;
    beats(1600, 1);
    n_cmp++;
    if (n_done !== 0 || n_keep !== 400) begin
      n_err++;
      $display("FAIL default_frame done/keeps got %0d/%0d want 0/400", n_done, n_keep);
    end
    idle(1);
    n_cmp++;
    if (bus.frame_done !== 1'b1 || bus.kept_count !== 11'd400 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL default_done done/kept/busy got %b/%0d/%b want 1/400/0",
               bus.frame_done, bus.kept_count, bus.busy);
    end
    idle(1);
    n_cmp++;
    if (bus.frame_done !== 1'b0 || n_done !== 1) begin
      n_err++;
      $display("FAIL default_once done/count got %b/%0d want 0/1", bus.frame_done, n_done);
    end
  endtask

  task automatic test_cfg();
    cycle(0, 0, 0, 1, 30, 10, 11, 20, 0);
    idle(1);
    n_cmp++;
    if (bus.cfg_err !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_reject_pulse got %b want 1", bus.cfg_err);
    end
    idle(1);
    n_cmp++;
    if (bus.cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_reject_single got %b want 0", bus.cfg_err);
    end
    beats(1600, 1);
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd400) begin
      n_err++;
      $display("FAIL cfg_rejected_kept got %0d want 400", bus.kept_count);
    end
    beats(100, 1);
    cycle(1, 1, 0, 1, 0, 0, 40, 1, 0);
    beats(1499, 0);
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd400) begin
      n_err++;
      $display("FAIL cfg_midframe_kept got %0d want 400", bus.kept_count);
    end
    beats(1600, 1);
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd40) begin
      n_err++;
      $display("FAIL cfg_newwin_kept got %0d want 40", bus.kept_count);
    end
  endtask

  task automatic test_ready_toggle();
    int bad;
    cycle(0, 0, 0, 1, 10, 10, 20, 20, 0);
    q_cx.delete();
    q_cy.delete();
    for (int i = 0; i < 3200; i++) cycle(1, (i % 2) == 0, i == 0, 0, 0, 0, 0, 0, 0);
    bad = (q_cx.size() != 1600) ? 1 : 0;
    for (int i = 0; i < q_cx.size() && i < 1600; i++)
      if (q_cx[i] != i % COLS || q_cy[i] != i / COLS) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL toggle_coords beats %0d bad %0d want beats 1600 bad 0", q_cx.size(), bad);
    end
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd400) begin
      n_err++;
      $display("FAIL toggle_kept got %0d want 400", bus.kept_count);
    end
  endtask

  task automatic test_mid_sof();
    n_done = 0; n_ferr = 0;
    beats(500, 1);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midsof_err ferr/busy got %b/%b want 1/1", bus.frame_err, bus.busy);
    end
    beats(1599, 0);
    n_cmp++;
    if (n_done !== 0 || n_ferr !== 1) begin
      n_err++;
      $display("FAIL midsof_nodone done/ferr got %0d/%0d want 0/1", n_done, n_ferr);
    end
    idle(1);
    n_cmp++;
    if (bus.frame_done !== 1'b1 || bus.kept_count !== 11'd400) begin
      n_err++;
      $display("FAIL midsof_done done/kept got %b/%0d want 1/400", bus.frame_done, bus.kept_count);
    end
  endtask

  task automatic test_reset_mid();
    beats(700, 1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.kept_count !== 11'd0) begin
      n_err++;
      $display("FAIL resetmid busy/kept got %b/%0d want 0/0", bus.busy, bus.kept_count);
    end
    n_keep = 0;
    beats(50, 0);
    n_cmp++;
    if (n_keep !== 0 || bus.busy !== 1'b0 || bus.cur_x !== 6'd0) begin
      n_err++;
      $display("FAIL resetmid_ignore keeps/busy/x got %0d/%b/%0d want 0/0/0", n_keep, bus.busy, bus.cur_x);
    end
  endtask

  task automatic test_sof_cfg();
    n_keep = 0;
    cycle(1, 1, 1, 1, 0, 0, 1, 1, 0);
    beats(1599, 0);
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd400 || n_keep !== 400) begin
      n_err++;
      $display("FAIL sofcfg_old kept/keeps got %0d/%0d want 400/400", bus.kept_count, n_keep);
    end
    n_keep = 0;
    beats(1, 1);
    n_cmp++;
    if (bus.keep !== 1'b1) begin
      n_err++;
      $display("FAIL sofcfg_origin keep got %b want 1", bus.keep);
    end
    beats(1599, 0);
    idle(1);
    n_cmp++;
    if (bus.kept_count !== 11'd1 || n_keep !== 1) begin
      n_err++;
      $display("FAIL sofcfg_new kept/keeps got %0d/%0d want 1/1", bus.kept_count, n_keep);
    end
  endtask

  initial begin
    bus.px_valid = 0; bus.px_ready = 0; bus.px_sof = 0; bus.cfg_wr = 0;
    bus.cfg_x1 = 0; bus.cfg_y1 = 0; bus.cfg_w = 0; bus.cfg_h = 0;
    m_busy = 0; m_x = 0; m_y = 0; m_kept = 0; m_kc = 0;
    m_sh = def_win(); m_ac = def_win();
    test_reset();
    test_default_frame();
    test_cfg();
    test_ready_toggle();
    test_mid_sof();
    test_reset_mid();
    test_sof_cfg();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
